seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; these are the ports clk and rst.
REQ-002 Parameter SETTLE, default 4, range 1..255, SHALL set the consecutive identical samples required before capture.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port seg_n  input  7  active-low segments {a,b,c,d,e,f,g}, with a at bit 6; synchronous to clk.
REQ-006 Port an_n  input  4  active-low digit strobes; bit i selects digit i; synchronous to clk.
REQ-007 Port digits  output  16  decoded hex values; digit i is in bits [4i+3:4i].
REQ-008 Port digit_valid  output  4  bit i is 1 when digit i holds a decoded legal pattern.
REQ-009 Port seg_err  output  4  bit i is 1 when the last capture of digit i was an illegal non-blank pattern.
REQ-010 Port frame_done  output  1  one-cycle pulse when all four digits have been captured.
REQ-011 Port frame_count  output  8  count of frame_done pulses; wraps 255 to 0.

Function
REQ-012 Legal patterns SHALL be given as segment-on values, with seg_n equal to the bitwise inverse: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47 (hex).
REQ-013 The FSM SHALL have exactly the states IDLE, SETTLE, CAPTURE and HOLD.
REQ-014 IDLE to SETTLE SHALL occur when exactly one an_n bit is 0; the pair {an_n, seg_n} is latched and the settle counter is set to 1.
REQ-015 In SETTLE, a sample equal to the latched pair SHALL increment the counter; when the counter equals SETTLE the FSM SHALL go to CAPTURE.
REQ-016 In SETTLE, a differing sample with one strobe active SHALL relatch the pair and reset the counter to 1; a sample with zero or multiple strobes active SHALL return the FSM to IDLE.
REQ-017 With SETTLE=1, the FSM SHALL go from IDLE directly to CAPTURE.
REQ-018 CAPTURE SHALL last one cycle and SHALL update digit i at its exit edge; the FSM then goes to HOLD.
REQ-019 Latency: if an identical pair is first sampled at edge k, outputs SHALL update at edge k+SETTLE+1.
REQ-020 On a legal pattern, CAPTURE SHALL write nibble i, set digit_valid[i]=1 and clear seg_err[i].
REQ-021 On a blank pattern (seg_n=7F), CAPTURE SHALL leave nibble i unchanged, set digit_valid[i]=0 and clear seg_err[i].
REQ-022 On any other pattern, CAPTURE SHALL leave nibble i unchanged, set digit_valid[i]=0 and set seg_err[i]=1.
REQ-023 The FSM SHALL stay in HOLD while the sample equals the latched pair; any change SHALL take it to IDLE, and a single active strobe SHALL be evaluated as for the IDLE transition in the same cycle.
REQ-024 Each CAPTURE SHALL set bit i of an internal captured mask.
REQ-025 When the mask becomes 1111, the block SHALL, on the same edge, pulse frame_done for one cycle, increment frame_count and clear the mask.
REQ-026 Recapturing a digit already in the mask SHALL not produce frame_done.
REQ-027 Capture order SHALL be irrelevant to frame_done.

Reset
REQ-028 Asserting rst SHALL immediately set the FSM to IDLE and clear digits, digit_valid, seg_err, frame_done, frame_count, the mask, the counter and the latched pair.
REQ-029 Reset mid-SETTLE or mid-CAPTURE SHALL abort the capture with no partial output update.
REQ-030 After rst is released, the first capture SHALL require a full SETTLE window.

Structure
REQ-031 Package seg7_pkg SHALL hold the 16 pattern constants, the blank constant, the FSM state enum and the SETTLE default.
REQ-032 The combinational lookup SHALL be a sub-module seg7_pattern_decode with input seg_n[6:0] and outputs hex[3:0], legal and blank.
REQ-033 All other logic SHALL be in seg7_scan_decoder.

Verification
REQ-034 With SETTLE=4, an_n=1110 and seg_n=~7E held for 6 cycles: digits[3:0]=0 and digit_valid=0001 at edge 5; no frame_done.
REQ-035 Scan digits 0..3 with patterns 3,A,b,F, each held 6 cycles: digits=F_bA3 (0xFBA3), digit_valid=1111, a single frame_done pulse and frame_count=1.
REQ-036 an_n=1100 for 10 cycles: no capture and outputs unchanged. Then seg_n=~12 on digit 2: seg_err=0100, digit_valid[2]=0 and nibble 2 unchanged.
REQ-037 seg_n toggles every 3 cycles with SETTLE=4: no capture. Pattern 8 held on digit 1 after a prior capture of 5: nibble 1=8.
REQ-038 Drive 256 complete frames: frame_count wraps to 0. Assert rst at the SETTLE count of 3: all outputs are 0, and the next capture needs 5 edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
package seg7_pkg;

  localparam int SETTLE_DEFAULT = 4;

  // Segment-on values {a,b,c,d,e,f,g}, a at bit 6; the bus carries the inverse.
  localparam logic [6:0] PAT_0 = 7'h7E;
  localparam logic [6:0] PAT_1 = 7'h30;
  localparam logic [6:0] PAT_2 = 7'h6D;
  localparam logic [6:0] PAT_3 = 7'h79;
  localparam logic [6:0] PAT_4 = 7'h33;
  localparam logic [6:0] PAT_5 = 7'h5B;
  localparam logic [6:0] PAT_6 = 7'h5F;
  localparam logic [6:0] PAT_7 = 7'h70;
  localparam logic [6:0] PAT_8 = 7'h7F;
  localparam logic [6:0] PAT_9 = 7'h7B;
  localparam logic [6:0] PAT_A = 7'h77;
  localparam logic [6:0] PAT_B = 7'h1F;
  localparam logic [6:0] PAT_C = 7'h4E;
  localparam logic [6:0] PAT_D = 7'h3D;
  localparam logic [6:0] PAT_E = 7'h4F;
  localparam logic [6:0] PAT_F = 7'h47;

  // All segments dark, as seen on the active-low bus.
  localparam logic [6:0] SEG_N_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  // True when exactly one active-low digit strobe is asserted.
  function automatic logic single_strobe(input logic [3:0] an_n);
    logic hit;
    hit = 1'b0;
    case (an_n)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to a hex nibble.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] hex,
  output logic       legal,
  output logic       blank
);

  logic [6:0] seg_on;

  assign seg_on = ~seg_n;
  assign blank  = (seg_n == SEG_N_BLANK);

  // Match the lit segments against the sixteen hex glyphs.
  always_comb begin
    hex   = 4'h0;
    legal = 1'b1;
    case (seg_on)
      PAT_0:   hex = 4'h0;
      PAT_1:   hex = 4'h1;
      PAT_2:   hex = 4'h2;
      PAT_3:   hex = 4'h3;
      PAT_4:   hex = 4'h4;
      PAT_5:   hex = 4'h5;
      PAT_6:   hex = 4'h6;
      PAT_7:   hex = 4'h7;
      PAT_8:   hex = 4'h8;
      PAT_9:   hex = 4'h9;
      PAT_A:   hex = 4'hA;
      PAT_B:   hex = 4'hB;
      PAT_C:   hex = 4'hC;
      PAT_D:   hex = 4'hD;
      PAT_E:   hex = 4'hE;
      PAT_F:   hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four hex digits from a multiplexed seven-segment display bus.
// A strobe/segment pair must be stable for SETTLE+1 samples before it is
// captured; a frame completes once every digit has been captured at least once.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  seg_err,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);
  // With a one-sample window there is nothing to count, so go straight to capture.
  localparam state_t ARM_STATE = (SETTLE == 1) ? ST_CAPTURE : ST_SETTLE;

  state_t     state, state_nxt;
  logic [3:0] lat_an, lat_an_nxt;
  logic [6:0] lat_seg, lat_seg_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] mask;
  logic       cap_en;
  logic       same;
  logic       strobe_ok;
  logic [3:0] pat_hex;
  logic       pat_legal;
  logic       pat_blank;
  logic [3:0] mask_merged;

  assign same        = (an_n == lat_an) && (seg_n == lat_seg);
  assign strobe_ok   = single_strobe(an_n);
  assign mask_merged = mask | ~lat_an;

  seg7_pattern_decode u_decode (
    .seg_n (lat_seg),
    .hex   (pat_hex),
    .legal (pat_legal),
    .blank (pat_blank)
  );

  // FSM state, latched strobe/segment pair and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lat_an  <= 4'h0;
      lat_seg <= 7'h00;
      cnt     <= 8'h00;
    end else begin
      state   <= state_nxt;
      lat_an  <= lat_an_nxt;
      lat_seg <= lat_seg_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next state: arm on a single strobe, count stable samples, capture, then hold.
  always_comb begin
    state_nxt   = state;
    lat_an_nxt  = lat_an;
    lat_seg_nxt = lat_seg;
    cnt_nxt     = cnt;
    cap_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (strobe_ok) begin
          lat_an_nxt  = an_n;
          lat_seg_nxt = seg_n;
          cnt_nxt     = 8'd1;
          state_nxt   = ARM_STATE;
        end
      end
      ST_SETTLE: begin
        if (same) begin
          if (cnt == SETTLE_CNT) begin
            state_nxt = ST_CAPTURE;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else if (strobe_ok) begin
          lat_an_nxt  = an_n;
          lat_seg_nxt = seg_n;
          cnt_nxt     = 8'd1;
          state_nxt   = ARM_STATE;
        end else begin
          cnt_nxt   = 8'd0;
          state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        cap_en    = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // A change of pair ends the hold; a new single strobe re-arms at once.
        if (!same) begin
          if (strobe_ok) begin
            lat_an_nxt  = an_n;
            lat_seg_nxt = seg_n;
            cnt_nxt     = 8'd1;
            state_nxt   = ARM_STATE;
          end else begin
            cnt_nxt   = 8'd0;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Digit registers, status flags and frame bookkeeping, updated on capture exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'h0000;
      digit_valid <= 4'h0;
      seg_err     <= 4'h0;
      frame_done  <= 1'b0;
      frame_count <= 8'h00;
      mask        <= 4'h0;
    end else begin
      frame_done <= 1'b0;
      if (cap_en) begin
        for (int i = 0; i < 4; i++) begin
          if (!lat_an[i]) begin
            if (pat_legal) begin
              digits[4*i +: 4] <= pat_hex;
            end
            digit_valid[i] <= pat_legal;
            seg_err[i]     <= !pat_legal && !pat_blank;
          end
        end
        if (mask_merged == 4'hF) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
          mask        <= 4'h0;
        end else begin
          mask <= mask_merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model plus directed scenarios.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  seg_err;
  logic        frame_done;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .seg_err     (seg_err),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] pat_on [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pair is captured once it has been seen on SETTLE+1
  // consecutive samples, counted from when the decoder could first watch it.
  logic [15:0] exp_digits = '0;
  logic [3:0]  exp_valid = '0;
  logic [3:0]  exp_err = '0;
  logic        exp_fd = 1'b0;
  logic [7:0]  exp_count = '0;
  logic [3:0]  exp_mask = '0;
  logic [3:0]  run_an = '0;
  logic [6:0]  run_seg = '0;
  int          run_start = 0;
  bit          run_captured = 1'b0;
  int          last_cap = -100;
  bit          fresh = 1'b1;
  int          t = 0;
  int          seen_fd = 0;

  always @(posedge clk) begin
    logic [3:0] a;
    logic [6:0] s;
    int eff;
    int idx;
    int hit;
    a = an_n;
    s = seg_n;
    t = t + 1;
    exp_fd = 1'b0;
    if (rst) begin
      exp_digits = '0; exp_valid = '0; exp_err = '0; exp_count = '0; exp_mask = '0;
      fresh = 1'b1; last_cap = -100; run_captured = 1'b0;
    end else begin
      if (!fresh && !run_captured && $countones(~run_an) == 1) begin
        eff = (last_cap + 1 > run_start) ? last_cap + 1 : run_start;
        if (t - 1 - eff == SETTLE) begin
          idx = 0;
          for (int i = 0; i < 4; i++) if (!run_an[i]) idx = i;
          hit = -1;
          for (int p = 0; p < 16; p++) if (pat_on[p] == ~run_seg) hit = p;
          if (hit >= 0) begin
            exp_digits[4*idx +: 4] = 4'(hit);
            exp_valid[idx] = 1'b1;
            exp_err[idx] = 1'b0;
          end else begin
            exp_valid[idx] = 1'b0;
            exp_err[idx] = (run_seg != 7'h7F);
          end
          exp_mask[idx] = 1'b1;
          if (exp_mask == 4'hF) begin
            exp_fd = 1'b1;
            exp_count = exp_count + 8'd1;
            exp_mask = '0;
          end
          last_cap = t;
          run_captured = 1'b1;
        end
      end
      if (fresh || a != run_an || s != run_seg) begin
        run_an = a; run_seg = s; run_start = t; run_captured = 1'b0; fresh = 1'b0;
      end
    end
    #1;
    check("digits", 32'(digits), 32'(exp_digits));
    check("digit_valid", 32'(digit_valid), 32'(exp_valid));
    check("seg_err", 32'(seg_err), 32'(exp_err));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("frame_count", 32'(frame_count), 32'(exp_count));
    if (frame_done) seen_fd++;
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an_n = a;
    seg_n = s;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] a;
    logic [6:0] s;
    int r;

    repeat (3) @(posedge clk);
    #2;
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_count", 32'(frame_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'hF, 7'h7F, 2);

    // Single digit 0 held: visible only on the sixth sample.
    drive(4'b1110, ~7'h7E, 5);
    check("lat_pre_valid", 32'(digit_valid), 32'h0);
    drive(4'b1110, ~7'h7E, 1);
    check("lat_valid", 32'(digit_valid), 32'h1);
    check("lat_nibble0", 32'(digits[3:0]), 32'h0);
    check("lat_no_frame", 32'(seen_fd), 32'd0);

    // Full scan 3, A, b, F.
    drive(4'b1110, ~7'h79, 6);
    drive(4'b1101, ~7'h77, 6);
    drive(4'b1011, ~7'h1F, 6);
    drive(4'b0111, ~7'h47, 6);
    check("scan_digits", 32'(digits), 32'hFBA3);
    check("scan_model_digits", 32'(exp_digits), 32'hFBA3);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_count", 32'(frame_count), 32'd1);
    check("scan_pulses", 32'(seen_fd), 32'd1);

    // Two strobes at once never capture; then an illegal glyph on digit 2.
    drive(4'b1100, ~7'h7E, 10);
    check("multi_digits", 32'(digits), 32'hFBA3);
    check("multi_valid", 32'(digit_valid), 32'hF);
    drive(4'b1011, ~7'h12, 6);
    check("illegal_err", 32'(seg_err), 32'h4);
    check("illegal_valid", 32'(digit_valid), 32'hB);
    check("illegal_digits", 32'(digits), 32'hFBA3);

    // Unstable pattern on digit 1 never settles; a steady 8 then replaces 5.
    drive(4'b1101, ~7'h5B, 6);
    check("steady5", 32'(digits[7:4]), 32'h5);
    for (int i = 0; i < 6; i++) drive(4'b1101, (i % 2 == 0) ? ~7'h7F : ~7'h7E, 3);
    check("toggle_nibble1", 32'(digits[7:4]), 32'h5);
    drive(4'b1101, ~7'h7F, 6);
    check("steady8", 32'(digits[7:4]), 32'h8);
    check("steady8_model", 32'(exp_digits[7:4]), 32'h8);

    // Randomized traffic, including stray strobes, blanks, junk and resets.
    for (int seg = 0; seg < 300; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 7) a = ~(4'b0001 << $urandom_range(0, 3));
      else a = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 19);
      if (r < 12) s = ~pat_on[$urandom_range(0, 15)];
      else if (r < 15) s = 7'h7F;
      else s = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 8);
      drive(a, s, n);
      if ($urandom_range(0, 59) == 0) pulse_rst();
    end

    // 256 complete frames from reset wrap the frame counter.
    pulse_rst();
    for (int f = 0; f < 256; f++) begin
      for (int d = 0; d < 4; d++) drive(~(4'b0001 << d), ~pat_on[$urandom_range(0, 15)], 6);
      if (f == 254) check("count_255", 32'(frame_count), 32'd255);
    end
    check("count_wrap", 32'(frame_count), 32'd0);
    check("count_wrap_model", 32'(exp_count), 32'd0);

    // Reset three samples into a settle window clears everything.
    drive(4'b1110, ~7'h30, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_err", 32'(seg_err), 32'h0);
    check("rst_fd", 32'(frame_done), 32'h0);
    check("rst_count", 32'(frame_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("post_rst_pre", 32'(digit_valid), 32'h0);
    @(posedge clk);
    #2;
    check("post_rst_valid", 32'(digit_valid), 32'h1);
    check("post_rst_nibble", 32'(digits[3:0]), 32'h1);

    drive(4'hF, 7'h7F, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
